// File: rtl/serial_subtractor_if.sv
// Start/done handshake and result bus for the bit-serial subtractor.
// The master drives the operands and start; the slave returns the difference and flags.
interface serial_subtractor_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             negative;
    logic             zero;
    logic             overflow;
    logic             carry;

    modport master (
        output start, A, B,
        input  busy, done, diff, negative, zero, overflow, carry
    );

    modport slave (
        input  start, A, B,
        output busy, done, diff, negative, zero, overflow, carry
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B: one full-adder cell per clock with B inverted, LSB first.
// The final bit's edge loads the difference and the N/Z/V/C flags and pulses done.
module serial_subtractor #(
    parameter int WIDTH = 64
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    serial_subtractor_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] r_q;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] diff_q;
    logic             negative_q;
    logic             zero_q;
    logic             overflow_q;
    logic             carry_q;
    logic             done_q;

    logic             nb;
    logic             prop;
    logic             sum_d;
    logic             c_d;
    logic [WIDTH-1:0] result_d;

    // One full-adder slice; c_q holds the carry into the current bit.
    assign nb       = ~b_sh_q[0];
    assign prop     = a_sh_q[0] ^ nb;
    assign sum_d    = prop ^ c_q;
    assign c_d      = (a_sh_q[0] & nb) | (c_q & prop);
    assign result_d = {sum_d, r_q[WIDTH-1:1]};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            r_q        <= '0;
            c_q        <= 1'b0;
            cnt_q      <= '0;
            diff_q     <= '0;
            negative_q <= 1'b0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            carry_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_sh_q  <= bus.A;
                        b_sh_q  <= bus.B;
                        c_q     <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    r_q    <= result_d;
                    c_q    <= c_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        // c_q here is still the carry into the MSB.
                        diff_q     <= result_d;
                        carry_q    <= c_d;
                        overflow_q <= c_q ^ c_d;
                        negative_q <= sum_d;
                        zero_q     <= (result_d == '0);
                        done_q     <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = done_q;
    assign bus.diff     = diff_q;
    assign bus.negative = negative_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = overflow_q;
    assign bus.carry    = carry_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed checks of serial_subtractor at WIDTH=64 and WIDTH=8
// against an arithmetic reference of A - B and its N/Z/V/C flags.
module tb_serial_subtractor;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    serial_subtractor_if #(.WIDTH(64)) if64 ();
    serial_subtractor_if #(.WIDTH(8))  if8 ();

    serial_subtractor #(.WIDTH(64)) dut64 (.clk_i(clk), .reset_i(reset), .bus(if64));
    serial_subtractor #(.WIDTH(8))  dut8  (.clk_i(clk), .reset_i(reset), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int w, input logic st, input logic [63:0] a, input logic [63:0] b);
        if (w == 64) begin
            if64.start = st; if64.A = a; if64.B = b;
        end else begin
            if8.start = st; if8.A = a[7:0]; if8.B = b[7:0];
        end
    endtask

    task automatic read_out(input int w, output logic [63:0] d, output logic [5:0] f);
        // f = {busy, done, negative, zero, overflow, carry}
        if (w == 64) begin
            d = if64.diff;
            f = {if64.busy, if64.done, if64.negative, if64.zero, if64.overflow, if64.carry};
        end else begin
            d = {56'd0, if8.diff};
            f = {if8.busy, if8.done, if8.negative, if8.zero, if8.overflow, if8.carry};
        end
    endtask

    // Present a request now; it is accepted on the next rising edge.
    task automatic launch(input int w, input logic [63:0] a, input logic [63:0] b);
        drive(w, 1'b1, a, b);
        @(posedge clk); #1;
        drive(w, 1'b0, 64'd0, 64'd0);
    endtask

    // Count edges until done is seen; -1 on timeout.
    task automatic wait_done(input int w, output int n);
        logic [63:0] d;
        logic [5:0]  f;
        n = 0;
        f = '0;
        while (n < 200 && !f[4]) begin
            @(posedge clk); #1;
            n++;
            read_out(w, d, f);
        end
        if (!f[4]) n = -1;
    endtask

    // Reference: plain modular and signed arithmetic on the operands.
    task automatic ref_sub(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                           output logic [63:0] d, output logic [3:0] flags);
        logic [63:0]        mask;
        logic [63:0]        a;
        logic [63:0]        b;
        logic signed [66:0] sa, sb, sd, one, maxv, minv;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        a = a_in & mask;
        b = b_in & mask;
        d = (a - b) & mask;
        one = 67'sd1;
        sa = $signed({3'b000, a});
        sb = $signed({3'b000, b});
        if (a[w-1]) sa = sa - (one <<< w);
        if (b[w-1]) sb = sb - (one <<< w);
        sd = sa - sb;
        maxv = (one <<< (w - 1)) - one;
        minv = -(one <<< (w - 1));
        flags = {d[w-1], (d == 64'd0), ((sd > maxv) || (sd < minv)), (a >= b)};
    endtask

    task automatic check_result(input string tag, input int w, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] d, ed;
        logic [5:0]  f;
        logic [3:0]  ef;
        ref_sub(w, a, b, ed, ef);
        read_out(w, d, f);
        check_val({tag, ".diff"}, d, ed);
        check_val({tag, ".nzvc"}, {60'd0, f[3:0]}, {60'd0, ef});
    endtask

    task automatic expect_out(input string tag, input logic [63:0] ed, input logic [3:0] ef);
        logic [63:0] d;
        logic [5:0]  f;
        read_out(64, d, f);
        check_val({tag, ".diff"}, d, ed);
        check_val({tag, ".nzvc"}, {60'd0, f[3:0]}, {60'd0, ef});
        $display("%s: diff=%h nzvc=%b", tag, d, f[3:0]);
    endtask

    initial begin
        int          lat;
        int          dcount;
        logic [63:0] d, a, b;
        logic [5:0]  f;

        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        drive(64, 1'b0, 64'd0, 64'd0);
        drive(8, 1'b0, 64'd0, 64'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        read_out(64, d, f);
        check_val("reset64", {d, f}, 70'd0);
        read_out(8, d, f);
        check_val("reset8", {d[7:0], f}, 14'd0);

        // 5 - 3 with exact timing of busy and done
        launch(64, 64'd5, 64'd3);
        read_out(64, d, f);
        check_val("sub53.busy", {63'd0, f[5]}, 64'd1);
        wait_done(64, lat);
        check_val("sub53.lat", lat, 64);
        read_out(64, d, f);
        check_val("sub53.busy_end", {63'd0, f[5]}, 64'd0);
        expect_out("sub53", 64'd2, 4'b0001);
        @(posedge clk); #1;
        read_out(64, d, f);
        check_val("sub53.done_pulse", {63'd0, f[4]}, 64'd0);

        launch(64, 64'd3, 64'd5);
        wait_done(64, lat);
        check_val("sub35.lat", lat, 64);
        expect_out("sub35", 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);

        launch(64, 64'd7, 64'd7);
        wait_done(64, lat);
        expect_out("sub77", 64'd0, 4'b0101);

        launch(64, 64'h8000_0000_0000_0000, 64'd1);
        wait_done(64, lat);
        expect_out("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);

        // Back-to-back: start raised in the done cycle itself
        launch(64, 64'd10, 64'd4);
        wait_done(64, lat);
        check_val("b2b.lat", lat, 64);
        expect_out("b2b", 64'd6, 4'b0001);

        // Start pulse mid-RUN with other operands must be ignored
        launch(64, 64'd100, 64'd1);
        repeat (10) @(posedge clk);
        #1 drive(64, 1'b1, 64'd55, 64'd99);
        @(posedge clk); #1;
        drive(64, 1'b0, 64'd0, 64'd0);
        wait_done(64, lat);
        check_val("ignore.lat", lat + 11, 64);
        expect_out("ignore", 64'd99, 4'b0001);

        // Reset at cycle 30 of RUN aborts with no done
        @(posedge clk); #1;
        launch(64, 64'd1234, 64'd5);
        repeat (29) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        read_out(64, d, f);
        check_val("abort.outs", {d, f}, 70'd0);
        dcount = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            read_out(64, d, f);
            if (f[4]) dcount++;
        end
        check_val("abort.nodone", dcount, 0);
        $display("abort: done pulses after reset=%0d", dcount);
        launch(64, 64'd9, 64'd2);
        wait_done(64, lat);
        expect_out("after_abort", 64'd7, 4'b0001);

        // Randomized comparison against the reference
        for (int i = 0; i < 1000; i++) begin
            int w;
            w = (i < 400) ? 64 : 8;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ((i % 50) == 7) b = a;
            launch(w, a, b);
            wait_done(w, lat);
            check_val("rand.lat", lat, w);
            check_result("rand", w, a, b);
            read_out(w, d, f);
            $display("rand w=%0d a=%h b=%h diff=%h nzvc=%b lat=%0d", w, a, b, d, f[3:0], lat);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
